// File: rtl/cart_defs_pkg.sv
// Shared types and constants for the MBC1 cartridge bus responder.
package cart_defs;

    typedef struct packed {
        logic       ram_en;
        logic [4:0] bank_lo;
        logic [1:0] bank_hi;
        logic       mode;
    } mbc1_regs_s;

    typedef enum logic [1:0] {REG_ROM0, REG_ROMX, REG_ERAM, REG_NONE} cart_region_e;

    typedef enum logic [1:0] {IDLE, LOOKUP, DRIVE, WRITE} cart_bus_state_e;

    localparam logic [3:0]  RAM_ENABLE_KEY = 4'hA;

    // Region bases on the cartridge address map
    localparam logic [15:0] ROM0_BASE = 16'h0000;
    localparam logic [15:0] ROMX_BASE = 16'h4000;
    localparam logic [15:0] ERAM_BASE = 16'hA000;

    // MBC1 register windows inside ROM space, selected by addr[14:13]
    localparam logic [1:0]  MBC_SEL_RAMEN  = 2'd0;
    localparam logic [1:0]  MBC_SEL_BANKLO = 2'd1;
    localparam logic [1:0]  MBC_SEL_BANKHI = 2'd2;
    localparam logic [1:0]  MBC_SEL_MODE   = 2'd3;

    localparam mbc1_regs_s  MBC1_REGS_RST = '{ram_en: 1'b0, bank_lo: 5'd1, bank_hi: 2'd0, mode: 1'b0};

    // Classify a bus address; the RAM window only answers when n_cs is low.
    function automatic cart_region_e decode_region(input logic [15:0] a, input logic n_cs);
        cart_region_e r;
        if (a[15] == ROM0_BASE[15])
            r = (a[14] == ROMX_BASE[14]) ? REG_ROMX : REG_ROM0;
        else if (a[15:13] == ERAM_BASE[15:13] && !n_cs)
            r = REG_ERAM;
        else
            r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/cart_bus_sync.sv
// Multi-flop synchronizer for a bundle of asynchronous bus pins.
module cart_bus_sync
    import cart_defs::*;
#(
    parameter int             W       = 1,
    parameter int             STAGES  = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_4mhz,
    input  logic         rst,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_out
);

    logic [STAGES-1:0][W-1:0] sync_q, sync_d;

    // Shift the pin value one stage deeper each cycle
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    // Synchronizer flops, parked at the idle pin level in reset
    always_ff @(posedge clk_4mhz) begin
        if (rst) sync_q <= {STAGES{RST_VAL}};
        else     sync_q <= sync_d;
    end

    assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/cart_bus_responder.sv
// MBC1 cartridge-side bus responder: ROM banking plus optional external RAM.
// Build option: define CART_EXT_RAM_EN to serve the 0xA000-0xBFFF RAM window;
// without it that window reads 0xFF and the RAM port is tied off.
module cart_bus_responder
    import cart_defs::*;
#(
    parameter int ROM_BANKS   = 64,
    parameter int RAM_BANKS   = 4,
    parameter int SYNC_STAGES = 2,
    localparam int ROM_AW     = $clog2(ROM_BANKS) + 14,
    localparam int RAM_AW     = $clog2(RAM_BANKS) + 13
) (
    input  logic              clk_4mhz,
    input  logic              rst,
    input  logic              bus_n_rst,
    input  logic              bus_n_cs,
    input  logic              bus_n_rd,
    input  logic              bus_n_wr,
    input  logic [15:0]       bus_addr,
    input  logic [7:0]        bus_d_in,
    output logic [7:0]        bus_d_out,
    output logic              bus_d_oe,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    logic        n_rst_s, n_cs_s, n_rd_s, n_wr_s;
    logic [15:0] addr_s;
    logic [7:0]  d_s;
    logic        rst_eff;

    cart_bus_sync #(.W(4), .STAGES(SYNC_STAGES), .RST_VAL(4'hF)) u_sync_strb (
        .clk_4mhz (clk_4mhz),
        .rst      (rst),
        .d_in     ({bus_n_rst, bus_n_cs, bus_n_rd, bus_n_wr}),
        .d_out    ({n_rst_s, n_cs_s, n_rd_s, n_wr_s})
    );

    cart_bus_sync #(.W(16), .STAGES(SYNC_STAGES)) u_sync_addr (
        .clk_4mhz (clk_4mhz),
        .rst      (rst),
        .d_in     (bus_addr),
        .d_out    (addr_s)
    );

    cart_bus_sync #(.W(8), .STAGES(SYNC_STAGES)) u_sync_data (
        .clk_4mhz (clk_4mhz),
        .rst      (rst),
        .d_in     (bus_d_in),
        .d_out    (d_s)
    );

    // The cart reset pin acts exactly like the local reset once synchronized
    assign rst_eff = rst | ~n_rst_s;

    // ROM byte address; shifting inside ROM_AW bits drops high bank bits (bank % ROM_BANKS)
    function automatic logic [ROM_AW-1:0] rom_map(input mbc1_regs_s r, input logic [14:0] a);
        logic [6:0] bank;
        if (a[14]) bank = {r.bank_hi, r.bank_lo};
        else       bank = r.mode ? {r.bank_hi, 5'd0} : 7'd0;
        return (ROM_AW'(bank) << 14) | ROM_AW'(a[13:0]);
    endfunction

`ifdef CART_EXT_RAM_EN
    // RAM byte address; same truncation trick gives bank_hi % RAM_BANKS
    function automatic logic [RAM_AW-1:0] ram_map(input mbc1_regs_s r, input logic [12:0] a);
        logic [1:0] bank;
        bank = r.mode ? r.bank_hi : 2'd0;
        return (RAM_AW'(bank) << 13) | RAM_AW'(a);
    endfunction
`endif

    cart_bus_state_e   state_q, state_d;
    mbc1_regs_s        regs_q, regs_d;
    cart_region_e      rd_region_q, rd_region_d;
    cart_region_e      region_s;
    logic [15:0]       wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              wr_n_cs_q, wr_n_cs_d;
    logic              n_wr_prev_q, n_wr_prev_d;
    logic              wr_done;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        d_out_q, d_out_d;
    logic              oe_q, oe_d;
    logic [7:0]        rd_data;
`ifdef CART_EXT_RAM_EN
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
`endif

    assign region_s = decode_region(addr_s, n_cs_s);
    assign wr_done  = ~n_wr_prev_q & n_wr_s;

    // Select the byte to put on the bus for the region latched at LOOKUP entry
    always_comb begin
        rd_data = 8'hFF;
        case (rd_region_q)
            REG_ROM0, REG_ROMX: rd_data = rom_rdata;
`ifdef CART_EXT_RAM_EN
            REG_ERAM:           if (regs_q.ram_en) rd_data = ram_rdata;
`endif
            default:            rd_data = 8'hFF;
        endcase
    end

    // Next-state logic: read handshake, write capture/commit, MBC register updates
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        rd_region_d = rd_region_q;
        rom_addr_d  = rom_addr_q;
        d_out_d     = d_out_q;
        oe_d        = oe_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_n_cs_d   = wr_n_cs_q;
        n_wr_prev_d = n_wr_s;
`ifdef CART_EXT_RAM_EN
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
`endif
        // Keep the last address/data seen while the write strobe is low
        if (!n_wr_s) begin
            wr_addr_d = addr_s;
            wr_data_d = d_s;
            wr_n_cs_d = n_cs_s;
        end

        case (state_q)
            IDLE: begin
                oe_d = 1'b0;
                if (wr_done) begin
                    state_d = WRITE;
                    if (!wr_addr_q[15]) begin
                        case (wr_addr_q[14:13])
                            MBC_SEL_RAMEN:  regs_d.ram_en  = (wr_data_q[3:0] == RAM_ENABLE_KEY);
                            MBC_SEL_BANKLO: regs_d.bank_lo = (wr_data_q[4:0] == 5'd0) ? 5'd1 : wr_data_q[4:0];
                            MBC_SEL_BANKHI: regs_d.bank_hi = wr_data_q[1:0];
                            MBC_SEL_MODE:   regs_d.mode    = wr_data_q[0];
                            default:        regs_d         = regs_q;
                        endcase
                    end
`ifdef CART_EXT_RAM_EN
                    else if (decode_region(wr_addr_q, wr_n_cs_q) == REG_ERAM && regs_q.ram_en) begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = ram_map(regs_q, wr_addr_q[12:0]);
                        ram_wdata_d = wr_data_q;
                    end
`endif
                end else if (!n_rd_s && n_wr_s && region_s != REG_NONE) begin
                    // Write wins when both strobes are low, hence the n_wr_s term
                    state_d     = LOOKUP;
                    rd_region_d = region_s;
                    if (region_s == REG_ERAM) begin
`ifdef CART_EXT_RAM_EN
                        ram_addr_d = ram_map(regs_q, addr_s[12:0]);
`endif
                    end else begin
                        rom_addr_d = rom_map(regs_q, addr_s[14:0]);
                    end
                end
            end
            LOOKUP: begin
                if (n_rd_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRIVE;
                    oe_d    = 1'b1;
                    d_out_d = rd_data;
                end
            end
            DRIVE: begin
                if (n_rd_s) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; the cart reset pin clears these too
    always_ff @(posedge clk_4mhz) begin
        if (rst_eff) begin
            state_q     <= IDLE;
            regs_q      <= MBC1_REGS_RST;
            rd_region_q <= REG_NONE;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_n_cs_q   <= 1'b1;
            n_wr_prev_q <= 1'b1;
            rom_addr_q  <= '0;
            d_out_q     <= 8'hFF;
            oe_q        <= 1'b0;
`ifdef CART_EXT_RAM_EN
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            rd_region_q <= rd_region_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_n_cs_q   <= wr_n_cs_d;
            n_wr_prev_q <= n_wr_prev_d;
            rom_addr_q  <= rom_addr_d;
            d_out_q     <= d_out_d;
            oe_q        <= oe_d;
`ifdef CART_EXT_RAM_EN
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
`endif
        end
    end

    assign bus_d_out = d_out_q;
    assign bus_d_oe  = oe_q;
    assign rom_addr  = rom_addr_q;

`ifdef CART_EXT_RAM_EN
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
`else
    // RAM port tied off; these bits only matter when the RAM window is built
    logic unused_ram_bits;
    assign unused_ram_bits = ^{ram_rdata, regs_q.ram_en, wr_n_cs_q, wr_data_q[7:5]};
    assign ram_addr  = '0;
    assign ram_wdata = '0;
    assign ram_we    = 1'b0;
`endif

endmodule
